// File: rtl/bram_request_master_pkg.sv
// bram_request_master_pkg: shared state encoding and width constants for the BRAM request master
package bram_request_master_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int NUM_BYTES = DEF_DATA_WIDTH / 8;
  localparam logic [NUM_BYTES-1:0] BE_ALL = '1;
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;
  function automatic logic be_full(input logic [NUM_BYTES-1:0] be);
    return be == BE_ALL;
  endfunction
endpackage

// File: rtl/bram_request_master_if.sv
// bram_request_master_if: core request/response channel plus BRAM port signals
interface bram_request_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [DATA_WIDTH/8-1:0] req_byte_en;
  logic [DATA_WIDTH-1:0]   req_write_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_is_write;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic                    bram_readEnable;
  logic                    bram_writeEnable;
  logic [ADDR_WIDTH-1:0]   bram_address;
  logic [DATA_WIDTH-1:0]   bram_writeData;
  logic [DATA_WIDTH-1:0]   bram_readData;
  modport slave (
    input  req_valid, req_write, req_address, req_byte_en, req_write_data, rsp_ready, bram_readData,
    output req_ready, rsp_valid, rsp_is_write, rsp_data,
           bram_readEnable, bram_writeEnable, bram_address, bram_writeData
  );
  modport master (
    output req_valid, req_write, req_address, req_byte_en, req_write_data, rsp_ready, bram_readData,
    input  req_ready, rsp_valid, rsp_is_write, rsp_data,
           bram_readEnable, bram_writeEnable, bram_address, bram_writeData
  );
endinterface

// File: rtl/bram_byte_merge.sv
// bram_byte_merge: per-byte select of new word where byte_en is set, old word otherwise
module bram_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_word,
  input  logic [DATA_WIDTH-1:0]   new_word,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   merged
);
  for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_lane
    assign merged[8*b +: 8] = byte_en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/bram_request_master.sv
// bram_request_master: turns core load/store requests into BRAM port cycles, with read-modify-write for partial stores
module bram_request_master
  import bram_request_master_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input logic clock,
  input logic reset,
  input logic scan,
  bram_request_master_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  state_t                state, state_n;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_out;
  logic [NB-1:0]         be_q;
  logic [DATA_WIDTH-1:0] wdata_q, word_q, word_n, wd_out, merged;
  bram_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_word(bus.bram_readData),
    .new_word(wdata_q),
    .byte_en (be_q),
    .merged  (merged)
  );
  // word_q is both the merge register and the response data
  always_comb begin
    state_n = state;
    word_n  = word_q;
    case (state)
      IDLE: if (bus.req_valid) begin
        state_n = !bus.req_write ? READ : ~|bus.req_byte_en ? RESP : (&bus.req_byte_en) ? WRITE : READ;
        word_n  = (bus.req_write && (&bus.req_byte_en)) ? bus.req_write_data : '0;
      end
      READ:    state_n = CAPTURE;
      CAPTURE: begin
        state_n = write_q ? WRITE : RESP;
        word_n  = write_q ? merged : bus.bram_readData;
      end
      WRITE:   state_n = RESP;
      RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      addr_out <= '0;
      wd_out   <= '0;
    end else begin
      state  <= state_n;
      word_q <= word_n;
      if (state == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        addr_q  <= bus.req_address;
        be_q    <= bus.req_byte_en;
        wdata_q <= bus.req_write_data;
      end
      // BRAM address/data only move when an access is about to happen
      if (state_n == READ || state_n == WRITE) addr_out <= (state == IDLE) ? bus.req_address : addr_q;
      if (state_n == WRITE) wd_out <= word_n;
    end
  end
  assign bus.req_ready        = state == IDLE && !reset;
  assign bus.rsp_valid        = state == RESP && !reset;
  assign bus.rsp_is_write     = write_q;
  assign bus.rsp_data         = word_q;
  assign bus.bram_readEnable  = state == READ;
  assign bus.bram_writeEnable = state == WRITE && !reset;
  assign bus.bram_address     = addr_out;
  assign bus.bram_writeData   = wd_out;
`ifndef SYNTHESIS
  int cycle;
  always @(negedge clock) begin
    cycle <= reset ? 0 : cycle + 1;
    if (scan && cycle >= SCAN_CYCLES_MIN && cycle <= SCAN_CYCLES_MAX)
      $display("[core %0d] cyc=%0d st=%s req v=%b r=%b w=%b a=%h be=%b wd=%h | bram re=%b we=%b a=%h wd=%h rd=%h | rsp v=%b r=%b w=%b d=%h",
               CORE, cycle, state.name(), bus.req_valid, bus.req_ready, bus.req_write, bus.req_address,
               bus.req_byte_en, bus.req_write_data, bus.bram_readEnable, bus.bram_writeEnable,
               bus.bram_address, bus.bram_writeData, bus.bram_readData, bus.rsp_valid, bus.rsp_ready,
               bus.rsp_is_write, bus.rsp_data);
  end
`endif
endmodule
